// File: rtl/fib_multicast.sv
// fib_multicast: fetch index n from a producer, compute F(n) mod 2^W, multicast it to NC consumers.
// Ports:
//   clock   - system clock, all state on rising edge
//   reset_  - asynchronous active-low reset
//   soc     - request to producer for the next index
//   eoc     - producer ready / index valid
//   n       - index (sampled only while waiting for eoc)
//   dav_    - per-consumer data-available, active low
//   rfd     - per-consumer ready-for-data, active high
//   out     - shared result, stable while any dav_ is low
//   ovf     - result overflowed W bits (only when FIB_OVF_EN is defined)
// Build option: define FIB_OVF_EN to add the ovf port and sticky overflow tracking.
module fib_multicast #(
  parameter int NW = 8,
  parameter int W  = 32,
  parameter int NC = 2
) (
  input  logic          clock,
  input  logic          reset_,
  output logic          soc,
  input  logic          eoc,
  input  logic [NW-1:0] n,
  output logic [NC-1:0] dav_,
  input  logic [NC-1:0] rfd,
  output logic [W-1:0]  out
`ifdef FIB_OVF_EN
  ,
  output logic          ovf
`endif
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAITN, S_CALC, S_OFFER, S_ACK} state_t;
  state_t r_state, w_next;
  logic [NW-1:0] r_cnt;
  logic [W-1:0] r_a, r_b, r_out, w_sum;
  logic [NC-1:0] r_dav;
`ifdef FIB_OVF_EN
  logic w_carry, r_aov, r_bov, r_ovf;
  assign {w_carry, w_sum} = {1'b0, r_a} + {1'b0, r_b};
  assign ovf = r_ovf;
`else
  assign w_sum = r_a + r_b;
`endif
  assign soc  = r_state == S_REQ;
  assign dav_ = r_dav;
  assign out  = r_out;
  always_ff @(posedge clock or negedge reset_)
    if (!reset_) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_REQ;
      S_REQ:   w_next = eoc ? S_REQ : S_WAITN;
      S_WAITN: w_next = eoc ? S_CALC : S_WAITN;
      S_CALC:  w_next = (r_cnt == '0) ? S_OFFER : S_CALC;
      S_OFFER: w_next = (&rfd) ? S_ACK : S_OFFER;
      S_ACK:   w_next = (&r_dav) ? S_REQ : S_ACK;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_out <= '0;
      r_dav <= '1;
    end else begin
      case (r_state)
        S_WAITN: if (eoc) begin
          r_cnt <= n;
          r_a   <= '0;
          r_b   <= W'(1);
        end
        S_CALC: if (r_cnt == '0) r_out <= r_a;
        else begin
          r_a   <= r_b;
          r_b   <= w_sum;
          r_cnt <= r_cnt - NW'(1);
        end
        S_OFFER: if (&rfd) r_dav <= '0;
        // a channel already released stays high; a pending one rises once its rfd drops
        S_ACK: r_dav <= r_dav | ~rfd;
        default: ;
      endcase
    end
  end
`ifdef FIB_OVF_EN
  // bov is sticky on b; aov follows a one step behind, so it flags the value that lands in out
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_aov <= 1'b0;
      r_bov <= 1'b0;
      r_ovf <= 1'b0;
    end else if (r_state == S_WAITN && eoc) begin
      r_aov <= 1'b0;
      r_bov <= 1'b0;
    end else if (r_state == S_CALC) begin
      if (r_cnt == '0) r_ovf <= r_aov;
      else begin
        r_aov <= r_bov;
        r_bov <= r_bov | w_carry;
      end
    end
  end
`endif
endmodule

// File: tb/tb_fib_multicast.sv
// tb_fib_multicast: scoreboard bench for fib_multicast with four consumers.
module tb_fib_multicast;
  logic clock, reset_, soc, eoc;
  logic [7:0] n;
  logic [3:0] dav_, rfd;
  logic [31:0] out;
`ifdef FIB_OVF_EN
  logic ovf;
`endif
  fib_multicast #(.NW(8), .W(32), .NC(4)) dut (
    .clock(clock), .reset_(reset_), .soc(soc), .eoc(eoc), .n(n),
    .dav_(dav_), .rfd(rfd), .out(out)
`ifdef FIB_OVF_EN
    , .ovf(ovf)
`endif
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  int tests = 0, failed = 0, cyc = 0;
  logic [32:0] q[4][$];
  int nq[$];
  int ack_delay[4], cnt[4], rise_cyc[4];
  logic [31:0] last_out[4];
  logic [31:0] held;
  logic [3:0] pdav, dropped, hold;
  logic prev_all, have_rise, psoc, lat_en, p_chk;
  int all_rise, pending, p_st, t0, last_n;
  function automatic logic [32:0] model(int k);
    logic [31:0] a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return {(k >= 48) ? 1'b1 : 1'b0, a};
  endfunction
  task automatic clear_book();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      cnt[i] = 0;
    end
    nq.delete();
    pdav = 4'hF; dropped = 4'h0; prev_all = 1'b1; have_rise = 1'b0;
    psoc = 1'b0; pending = 0; p_st = 0; p_chk = 1'b0; eoc = 1'b0; rfd = ~hold;
  endtask
  task automatic tick();
    logic [32:0] e;
    @(negedge clock);
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (dropped[i]) begin
        tests++;
        if (dav_[i] !== 1'b1) begin failed++; $display("FAIL dav_rise ch%0d: got %b, want 1", i, dav_[i]); end
        dropped[i] = 1'b0;
        rise_cyc[i] = cyc;
        rfd[i] = ~hold[i];
      end else if (dav_[i] === 1'b0) begin
        if (pdav[i]) begin
          tests++;
          if (rfd[i] !== 1'b1) begin failed++; $display("FAIL fall_rfd ch%0d: rfd=%b, want 1", i, rfd[i]); end
          tests++;
          if (q[i].size() == 0) begin failed++; $display("FAIL extra_result ch%0d: out=%h with nothing expected", i, out); end
          else begin
            e = q[i].pop_front();
            if (out !== e[31:0]) begin failed++; $display("FAIL result ch%0d: got %h, want %h", i, out, e[31:0]); end
`ifdef FIB_OVF_EN
            tests++;
            if (ovf !== e[32]) begin failed++; $display("FAIL ovf ch%0d: got %b, want %b", i, ovf, e[32]); end
`endif
          end
          held = out;
          last_out[i] = out;
          if (i == 0 && lat_en) begin
            tests++;
            if (cyc - t0 != last_n + 3) begin failed++; $display("FAIL latency n=%0d: got %0d, want %0d", last_n, cyc - t0, last_n + 3); end
          end
          cnt[i] = ack_delay[i];
        end else begin
          tests++;
          if (out !== held) begin failed++; $display("FAIL out_hold ch%0d: got %h, want %h", i, out, held); end
        end
        if (cnt[i] == 0) begin rfd[i] = 1'b0; dropped[i] = 1'b1; end
        else cnt[i]--;
      end else rfd[i] = ~hold[i];
      pdav[i] = dav_[i];
    end
    if ((&dav_) && !prev_all) begin
      all_rise = cyc;
      have_rise = 1'b1;
      if (pending > 0) pending--;
    end
    prev_all = &dav_;
    if (soc === 1'b1 && !psoc && have_rise) begin
      tests++;
      if (cyc != all_rise + 1) begin failed++; $display("FAIL soc_after_ack: got cycle %0d, want %0d", cyc, all_rise + 1); end
      have_rise = 1'b0;
    end
    psoc = soc;
    case (p_st)
      0: if (soc === 1'b1) begin p_st = 1; p_chk = 1'b1; end
      1: begin
        if (p_chk) begin
          tests++;
          if (soc !== 1'b0) begin failed++; $display("FAIL soc_pulse: got %b, want 0", soc); end
          p_chk = 1'b0;
        end
        if (nq.size() != 0) begin
          last_n = nq.pop_front();
          n = 8'(last_n);
          eoc = 1'b1;
          for (int i = 0; i < 4; i++) q[i].push_back(model(last_n));
          t0 = cyc;
          pending++;
          p_st = 2;
        end
      end
      default: begin eoc = 1'b0; n = 8'($urandom); p_st = 0; end
    endcase
  endtask
  task automatic wait_done();
    int k = 0;
    while ((nq.size() != 0 || pending != 0) && k < 5000) begin tick(); k++; end
    tests++;
    if (k >= 5000) begin failed++; $display("FAIL timeout: pending=%0d queued=%0d, want 0", pending, nq.size()); end
  endtask
  task automatic test_reset();
    reset_ = 1'b1; eoc = 1'b0; n = 8'd0; hold = 4'h0; lat_en = 1'b1;
    clear_book();
    #2 reset_ = 1'b0;
    repeat (3) tick();
    tests++;
    if (soc !== 1'b0 || dav_ !== 4'hF || out !== 32'h0) begin
      failed++; $display("FAIL reset_state: soc=%b dav_=%b out=%h, want 0 1111 0", soc, dav_, out);
    end
`ifdef FIB_OVF_EN
    tests++;
    if (ovf !== 1'b0) begin failed++; $display("FAIL reset_ovf: got %b, want 0", ovf); end
`endif
    reset_ = 1'b1;
    tick();
    tests++;
    if (soc !== 1'b1) begin failed++; $display("FAIL soc_after_reset: got %b, want 1", soc); end
  endtask
  task automatic test_small();
    for (int i = 0; i < 4; i++) ack_delay[i] = 0;
    nq.push_back(0);
    nq.push_back(1);
    wait_done();
    tests++;
    if (last_out[0] !== 32'h1) begin failed++; $display("FAIL n1_value: got %h, want 00000001", last_out[0]); end
  endtask
  task automatic test_sweep();
    ack_delay = '{1, 3, 0, 2};
    for (int k = 2; k <= 40; k++) nq.push_back(k);
    wait_done();
    tests++;
    if (last_out[0] !== 32'h06197ECB || last_out[1] !== 32'h06197ECB) begin
      failed++; $display("FAIL n40_value: got %h/%h, want 06197ecb", last_out[0], last_out[1]);
    end
  endtask
  task automatic test_ovf();
    ack_delay = '{0, 1, 0, 1};
    nq.push_back(47);
    wait_done();
    tests++;
    if (last_out[0] !== 32'hB11924E1) begin failed++; $display("FAIL n47_value: got %h, want b11924e1", last_out[0]); end
    nq.push_back(48);
    nq.push_back(100);
    wait_done();
  endtask
  task automatic test_hold();
    logic early = 1'b0;
    ack_delay = '{1, 1, 1, 1};
    hold[2] = 1'b1;
    lat_en = 1'b0;
    nq.push_back(5);
    repeat (30) begin
      tick();
      if (dav_ !== 4'hF) early = 1'b1;
    end
    tests++;
    if (early) begin failed++; $display("FAIL hold_nofall: dav_ fell while rfd[2]=0, want 1111"); end
    hold[2] = 1'b0;
    tick();
    tick();
    tests++;
    if (dav_ !== 4'h0) begin failed++; $display("FAIL all_fall: got %b, want 0000", dav_); end
    wait_done();
    lat_en = 1'b1;
  endtask
  task automatic test_reverse();
    ack_delay = '{7, 5, 3, 1};
    nq.push_back(10);
    wait_done();
    tests++;
    if (!(rise_cyc[3] < rise_cyc[2] && rise_cyc[2] < rise_cyc[1] && rise_cyc[1] < rise_cyc[0]) || rise_cyc[0] - rise_cyc[3] != 6) begin
      failed++; $display("FAIL reverse_order: rises %0d %0d %0d %0d, want ascending 3..0 spanning 6", rise_cyc[0], rise_cyc[1], rise_cyc[2], rise_cyc[3]);
    end
    repeat (3) tick();
  endtask
  task automatic test_reset_mid_ack();
    int k = 0;
    ack_delay = '{0, 20, 20, 20};
    nq.push_back(6);
    while (!(dav_[0] === 1'b1 && dav_[1] === 1'b0 && pending > 0) && k < 200) begin tick(); k++; end
    tests++;
    if (k >= 200) begin failed++; $display("FAIL mid_ack_reach: dav_=%b, want 1110", dav_); end
    reset_ = 1'b0;
    #1;
    tests++;
    if (soc !== 1'b0 || dav_ !== 4'hF || out !== 32'h0) begin
      failed++; $display("FAIL mid_ack_reset: soc=%b dav_=%b out=%h, want 0 1111 0", soc, dav_, out);
    end
    clear_book();
    tick();
    tick();
    reset_ = 1'b1;
    tick();
    tests++;
    if (soc !== 1'b1) begin failed++; $display("FAIL soc_after_mid_reset: got %b, want 1", soc); end
  endtask
  initial begin
    test_reset();
    test_small();
    test_sweep();
    test_ovf();
    test_hold();
    test_reverse();
    test_reset_mid_ack();
    ack_delay = '{0, 0, 0, 0};
    nq.push_back(12);
    wait_done();
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (q[i].size() != 0) begin failed++; $display("FAIL leftover ch%0d: %0d results undelivered, want 0", i, q[i].size()); end
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end
endmodule
